ls_unit: RTL and testbench
==========================

LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 ex_en  in  1  issue valid from the load/store reservation buffer.
REQ-004 ex_op  in  `OpBus  opcode: LB, LH, LW, LBU, LHU, SB, SH, SW or NOP.
REQ-005 ex_base  in  `DataBus  base register value.
REQ-006 ex_src  in  `DataBus  store data.
REQ-007 ex_imm  in  `DataBus  sign-extended offset.
REQ-008 ex_tag / ex_name  in  `TagBus / `NameBus  result tag / destination register name.
REQ-009 ex_ready  out  1  read-enable to the buffer.
REQ-010 mem_req / mem_we  out  1 / 1  byte request / write strobe.
REQ-011 mem_addr  out  32  byte address.
REQ-012 mem_wdata  out  8  write byte.
REQ-013 mem_ack / mem_rdata  in  1 / 8  byte accepted; read byte is valid in the ack cycle.
REQ-014 cdb_en / cdb_tag / cdb_data / cdb_name  out  1 / `TagBus / `DataBus / `NameBus  CDB broadcast.
REQ-015 misalign  out  1  misaligned-access flag, qualified by cdb_en.

Function
REQ-016 States are IDLE, BUSY and DONE, held in a registered FSM.
REQ-017 ex_ready SHALL equal (state==IDLE && !ex_en), so the buffer never issues twice before capture.
REQ-018 In IDLE, an ex_en with a non-NOP opcode is captured: addr=ex_base+ex_imm (mod 2^32), then go to BUSY with byte index k=0.
REQ-019 In IDLE, ex_en with NOP or an undefined opcode SHALL be dropped; state stays IDLE.
REQ-020 Byte count n is 1 for LB/LBU/SB, 2 for LH/LHU/SH, and 4 for LW/SW.
REQ-021 In BUSY: mem_req=1, mem_addr=addr+k, mem_we=1 for stores, mem_wdata=src[8k+7:8k]; little-endian.
REQ-022 On mem_ack in BUSY: loads latch mem_rdata into byte k; k increments; after ack with k==n-1, go to DONE.
REQ-023 Without mem_ack, all mem_* outputs SHALL hold stable.
REQ-024 In DONE, for exactly one cycle: cdb_en=1, cdb_tag=captured tag, cdb_name=captured name; then go to IDLE.
REQ-025 Load cdb_data: LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-026 Store result: cdb_data=`dataFree and cdb_name=`nameFree, so the tag is released with no register write.
REQ-027 Outside DONE: cdb_en=0, cdb_tag=`tagFree, cdb_data=`dataFree, cdb_name=`nameFree, misalign=0.
REQ-028 Outside BUSY: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 ex_en received outside IDLE SHALL be ignored.
REQ-030 Best-case latency is capture edge + n ack cycles + 1 DONE cycle.

Reset
REQ-031 rst SHALL force IDLE, k=0 and all outputs to REQ-027/REQ-028 values immediately, including mid-BUSY; a partial store is abandoned.
REQ-032 After rst deasserts, ex_ready=1 in the first cycle if ex_en=0.

Configuration
REQ-033 Macro LS_ALIGN_CHECK_EN controls the alignment check.
REQ-034 Defined: on capture, an access is misaligned if it is halfword with addr[0]!=0 or word with addr[1:0]!=0.
REQ-035 Defined, misaligned access: skip BUSY (no mem_req), go straight to DONE with misalign=1 and cdb_data=`dataFree.
REQ-036 Not defined: all accesses are performed byte-serially regardless of alignment, and misalign is tied to 0.

Verification
REQ-037 LW, base=0x100, imm=4, memory 0x104..0x107 = 78 56 34 12, ack every cycle -> addresses 0x104..0x107, one cdb_en pulse with data 0x12345678 and the issued tag/name, 5 cycles after capture.
REQ-038 LB at a byte of 0x80 -> cdb_data 0xFFFFFF80; LBU at the same byte -> 0x00000080.
REQ-039 SH, src=0xAABBCCDD, addr=0x20, ack delayed 3 cycles per byte -> writes DD to 0x20 and CC to 0x21, address and data stable while waiting; cdb_name=`nameFree.
REQ-040 ex_en held across a transaction -> ex_ready stays 0 and exactly one access is performed.
REQ-041 rst asserted after the first SW byte ack -> mem_req falls asynchronously, no CDB pulse, and the unit is IDLE afterwards.
REQ-042 With LS_ALIGN_CHECK_EN, LW at 0x102 -> no mem_req, cdb_en=1 and misalign=1 in the cycle after capture; without the macro the same access reads bytes 0x102..0x105.

Source files
------------

// File: rtl/ls_unit.sv
// Byte-serial load/store unit: captures one memory op, walks it over an 8-bit port, broadcasts on the CDB.
// Optional build macro LS_ALIGN_CHECK_EN rejects misaligned halfword/word accesses without touching memory.
`ifndef LS_UNIT_DEFS
`define LS_UNIT_DEFS
`define OpBus    3:0
`define DataBus  31:0
`define TagBus   4:0
`define NameBus  4:0
`define dataFree 32'h0000_0000
`define tagFree  5'h00
`define nameFree 5'h00
`define OP_NOP   4'h0
`define OP_LB    4'h1
`define OP_LH    4'h2
`define OP_LW    4'h3
`define OP_LBU   4'h4
`define OP_LHU   4'h5
`define OP_SB    4'h6
`define OP_SH    4'h7
`define OP_SW    4'h8
`endif

module ls_unit (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_en,
  input  logic [`OpBus]   ex_op,
  input  logic [`DataBus] ex_base,
  input  logic [`DataBus] ex_src,
  input  logic [`DataBus] ex_imm,
  input  logic [`TagBus]  ex_tag,
  input  logic [`NameBus] ex_name,
  output logic            ex_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [7:0]      mem_wdata,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic            cdb_en,
  output logic [`TagBus]  cdb_tag,
  output logic [`DataBus] cdb_data,
  output logic [`NameBus] cdb_name,
  output logic            misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg;
  logic [1:0]      k_reg;
  logic [1:0]      last_reg;
  logic            store_reg;
  logic [`OpBus]   op_reg;
  logic [31:0]     addr_reg;
  logic [31:0]     src_reg;
  logic [31:0]     rbytes_reg;
  logic [`TagBus]  tag_reg;
  logic [`NameBus] name_reg;

  logic [31:0] ex_addr;
  logic        op_ok;
  logic        op_store;
  logic [1:0]  op_last;
  logic        mis_cap;
  logic [1:0]  k_inc;
  logic [31:0] src_shift;
  logic [31:0] merged;
  logic [31:0] load_word;

  assign ex_addr   = ex_base + ex_imm;
  assign k_inc     = k_reg + 2'd1;
  assign src_shift = src_reg >> {k_inc, 3'b000};
  assign ex_ready  = (state_reg == IDLE) && !ex_en;

  always_comb begin
    op_ok    = 1'b1;
    op_store = 1'b0;
    op_last  = 2'd0;
    case (ex_op)
      `OP_LB, `OP_LBU: op_last = 2'd0;
      `OP_LH, `OP_LHU: op_last = 2'd1;
      `OP_LW:          op_last = 2'd3;
      `OP_SB:          op_store = 1'b1;
      `OP_SH: begin
        op_store = 1'b1;
        op_last  = 2'd1;
      end
      `OP_SW: begin
        op_store = 1'b1;
        op_last  = 2'd3;
      end
      default:         op_ok = 1'b0;
    endcase
  end

`ifdef LS_ALIGN_CHECK_EN
  assign mis_cap = ((op_last == 2'd1) && ex_addr[0]) ||
                   ((op_last == 2'd3) && (ex_addr[1:0] != 2'b00));
`else
  assign mis_cap = 1'b0;
  assign misalign = 1'b0;
`endif

  // The byte arriving in this ack cycle is merged in place so the final result is ready on the last ack.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = (k_reg == 2'(gi)) ? mem_rdata : rbytes_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    load_word = merged;
    case (op_reg)
      `OP_LB:  load_word = {{24{merged[7]}}, merged[7:0]};
      `OP_LH:  load_word = {{16{merged[15]}}, merged[15:0]};
      `OP_LBU: load_word = {24'h0, merged[7:0]};
      `OP_LHU: load_word = {16'h0, merged[15:0]};
      default: load_word = merged;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      k_reg      <= 2'd0;
      last_reg   <= 2'd0;
      store_reg  <= 1'b0;
      op_reg     <= `OP_NOP;
      addr_reg   <= 32'h0;
      src_reg    <= 32'h0;
      rbytes_reg <= 32'h0;
      tag_reg    <= `tagFree;
      name_reg   <= `nameFree;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 8'h0;
      cdb_en     <= 1'b0;
      cdb_tag    <= `tagFree;
      cdb_data   <= `dataFree;
      cdb_name   <= `nameFree;
`ifdef LS_ALIGN_CHECK_EN
      misalign   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (ex_en && op_ok) begin
            op_reg     <= ex_op;
            store_reg  <= op_store;
            last_reg   <= op_last;
            addr_reg   <= ex_addr;
            src_reg    <= ex_src;
            tag_reg    <= ex_tag;
            name_reg   <= ex_name;
            k_reg      <= 2'd0;
            rbytes_reg <= 32'h0;
            if (mis_cap) begin
              // Misaligned: report immediately, memory is never touched.
              state_reg <= DONE;
              cdb_en    <= 1'b1;
              cdb_tag   <= ex_tag;
              cdb_data  <= `dataFree;
              cdb_name  <= op_store ? `nameFree : ex_name;
`ifdef LS_ALIGN_CHECK_EN
              misalign  <= 1'b1;
`endif
            end else begin
              state_reg <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= op_store;
              mem_addr  <= ex_addr;
              mem_wdata <= ex_src[7:0];
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rbytes_reg <= merged;
            if (k_reg == last_reg) begin
              state_reg <= DONE;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= 32'h0;
              mem_wdata <= 8'h0;
              cdb_en    <= 1'b1;
              cdb_tag   <= tag_reg;
              cdb_data  <= store_reg ? `dataFree : load_word;
              cdb_name  <= store_reg ? `nameFree : name_reg;
            end else begin
              k_reg     <= k_inc;
              mem_addr  <= addr_reg + {30'h0, k_inc};
              mem_wdata <= src_shift[7:0];
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          k_reg     <= 2'd0;
          cdb_en    <= 1'b0;
          cdb_tag   <= `tagFree;
          cdb_data  <= `dataFree;
          cdb_name  <= `nameFree;
`ifdef LS_ALIGN_CHECK_EN
          misalign  <= 1'b0;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit: byte-wide memory responder, CDB scoreboard, access log.
`ifndef LS_UNIT_DEFS
`define LS_UNIT_DEFS
`define OpBus    3:0
`define DataBus  31:0
`define TagBus   4:0
`define NameBus  4:0
`define dataFree 32'h0000_0000
`define tagFree  5'h00
`define nameFree 5'h00
`define OP_NOP   4'h0
`define OP_LB    4'h1
`define OP_LH    4'h2
`define OP_LW    4'h3
`define OP_LBU   4'h4
`define OP_LHU   4'h5
`define OP_SB    4'h6
`define OP_SH    4'h7
`define OP_SW    4'h8
`endif

module tb_ls_unit;
  logic            clk = 1'b0;
  logic            rst;
  logic            ex_en;
  logic [`OpBus]   ex_op;
  logic [`DataBus] ex_base, ex_src, ex_imm;
  logic [`TagBus]  ex_tag;
  logic [`NameBus] ex_name;
  logic            ex_ready;
  logic            mem_req, mem_we;
  logic [31:0]     mem_addr;
  logic [7:0]      mem_wdata;
  logic            mem_ack;
  logic [7:0]      mem_rdata;
  logic            cdb_en;
  logic [`TagBus]  cdb_tag;
  logic [`DataBus] cdb_data;
  logic [`NameBus] cdb_name;
  logic            misalign;

  ls_unit dut (
    .clk(clk), .rst(rst), .ex_en(ex_en), .ex_op(ex_op), .ex_base(ex_base),
    .ex_src(ex_src), .ex_imm(ex_imm), .ex_tag(ex_tag), .ex_name(ex_name),
    .ex_ready(ex_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_name(cdb_name),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] tag; logic [31:0] data; logic [4:0] name; logic mis; } cdb_exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [7:0] wdata; } acc_t;

  cdb_exp_t   sb[$];
  acc_t       log_q[$];
  logic [7:0] mem_model [logic [31:0]];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cap_cyc = 0;
  int last_cdb_cyc = 0;
  int pulses = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  bit waiting = 1'b0;
  logic [31:0] pa;
  logic [7:0]  pw;
  logic        pwe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    tests++;
    fails++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Memory responder and CDB monitor, both sampled on the falling edge.
  initial begin
    cdb_exp_t e;
    acc_t     a;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (cdb_en === 1'b1) begin
        pulses++;
        last_cdb_cyc = cyc;
        if (sb.size() == 0) begin
          fail_now("unexpected_cdb_pulse");
        end else begin
          e = sb.pop_front();
          check("cdb_tag", 32'(cdb_tag), 32'(e.tag));
          check("cdb_data", cdb_data, e.data);
          check("cdb_name", 32'(cdb_name), 32'(e.name));
          check("misalign", 32'(misalign), 32'(e.mis));
        end
      end
      if (rst || mem_req !== 1'b1) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
        waiting  = 1'b0;
      end else begin
        if (waiting) begin
          check("hold_addr", mem_addr, pa);
          check("hold_wdata", 32'(mem_wdata), 32'(pw));
          check("hold_we", 32'(mem_we), 32'(pwe));
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = 8'h00;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else if (mem_model.exists(mem_addr)) mem_rdata = mem_model[mem_addr];
          a.addr = mem_addr; a.we = mem_we; a.wdata = mem_wdata;
          log_q.push_back(a);
          wait_cnt = 0;
          waiting  = 1'b0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt++;
          waiting  = 1'b1;
          pa = mem_addr; pw = mem_wdata; pwe = mem_we;
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] src, input logic [4:0] tag, input logic [4:0] name,
                       input bit push, input logic [31:0] exp_data, input logic [4:0] exp_name,
                       input logic exp_mis, input bit hold);
    cdb_exp_t e;
    @(negedge clk);
    ex_en = 1'b1; ex_op = op; ex_base = base; ex_imm = imm; ex_src = src;
    ex_tag = tag; ex_name = name;
    if (push) begin
      e.tag = tag; e.data = exp_data; e.name = exp_name; e.mis = exp_mis;
      sb.push_back(e);
    end
    @(posedge clk);
    cap_cyc = cyc;
    #1;
    if (!hold) ex_en = 1'b0;
  endtask

  task automatic wait_cdb(input string tag, output int lat);
    int start;
    bit seen;
    start = pulses;
    seen  = 1'b0;
    lat   = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (pulses > start) seen = 1'b1;
    end
    if (!seen) fail_now(tag);
    else lat = last_cdb_cyc - cap_cyc;
  endtask

  initial begin
    int lat;
    int base_log;
    int p0;
    bit seen;
    rst = 1'b1; ex_en = 1'b0; ex_op = `OP_NOP; ex_base = 0; ex_src = 0; ex_imm = 0;
    ex_tag = 0; ex_name = 0;
    mem_model[32'h104] = 8'h78; mem_model[32'h105] = 8'h56;
    mem_model[32'h106] = 8'h34; mem_model[32'h107] = 8'h12;
    mem_model[32'h102] = 8'hAA; mem_model[32'h103] = 8'hBB;
    mem_model[32'h200] = 8'h80;
    mem_model[32'h300] = 8'h34; mem_model[32'h301] = 8'h92;
    mem_model[32'h000] = 8'h7F;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_cdb_en", 32'(cdb_en), 32'd0);
    check("rst_cdb_tag", 32'(cdb_tag), 32'(`tagFree));
    check("rst_cdb_data", cdb_data, `dataFree);
    check("rst_misalign", 32'(misalign), 32'd0);

    // LW 0x104: four reads, result five cycles after capture
    base_log = log_q.size();
    issue(`OP_LW, 32'h100, 32'h4, 32'h0, 5'd3, 5'd7, 1'b1, 32'h12345678, 5'd7, 1'b0, 1'b0);
    wait_cdb("lw_timeout", lat);
    check("lw_latency", 32'(lat), 32'd5);
    check("lw_accesses", 32'(log_q.size() - base_log), 32'd4);
    for (int i = 0; i < 4 && base_log + i < log_q.size(); i++)
      check($sformatf("lw_addr%0d", i), log_q[base_log + i].addr, 32'h104 + 32'(i));

    // Sign/zero extension of bytes and halfwords, plus address wrap
    issue(`OP_LB, 32'h200, 32'h0, 32'h0, 5'd4, 5'd8, 1'b1, 32'hFFFFFF80, 5'd8, 1'b0, 1'b0);
    wait_cdb("lb_timeout", lat);
    issue(`OP_LBU, 32'h1F0, 32'h10, 32'h0, 5'd5, 5'd9, 1'b1, 32'h00000080, 5'd9, 1'b0, 1'b0);
    wait_cdb("lbu_timeout", lat);
    issue(`OP_LH, 32'h310, 32'hFFFFFFF0, 32'h0, 5'd6, 5'd10, 1'b1, 32'hFFFF9234, 5'd10, 1'b0, 1'b0);
    wait_cdb("lh_timeout", lat);
    check("lh_latency", 32'(lat), 32'd3);
    issue(`OP_LB, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd7, 5'd11, 1'b1, 32'h0000007F, 5'd11, 1'b0, 1'b0);
    wait_cdb("wrap_timeout", lat);
    check("wrap_addr", log_q[log_q.size() - 1].addr, 32'h0);

    // SH with slow acks: bytes DD, CC to 0x20/0x21, tag released without a name
    ack_delay = 3;
    base_log  = log_q.size();
    issue(`OP_SH, 32'h1C, 32'h4, 32'hAABBCCDD, 5'd9, 5'd12, 1'b1, `dataFree, `nameFree, 1'b0, 1'b0);
    wait_cdb("sh_timeout", lat);
    check("sh_accesses", 32'(log_q.size() - base_log), 32'd2);
    if (log_q.size() - base_log == 2) begin
      check("sh_addr0", log_q[base_log].addr, 32'h20);
      check("sh_data0", 32'(log_q[base_log].wdata), 32'hDD);
      check("sh_we0", 32'(log_q[base_log].we), 32'd1);
      check("sh_addr1", log_q[base_log + 1].addr, 32'h21);
      check("sh_data1", 32'(log_q[base_log + 1].wdata), 32'hCC);
    end
    ack_delay = 0;

    // ex_en held for the whole transaction (with a changing opcode): one access only
    base_log = log_q.size();
    issue(`OP_LHU, 32'h300, 32'h0, 32'h0, 5'd10, 5'd13, 1'b1, 32'h00009234, 5'd13, 1'b0, 1'b1);
    ex_op = `OP_SW;
    p0 = pulses;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      check("held_ex_ready", 32'(ex_ready), 32'd0);
      if (pulses > p0) begin
        seen = 1'b1;
        ex_en = 1'b0;
      end
    end
    if (!seen) fail_now("held_timeout");
    repeat (3) @(negedge clk);
    #1;
    check("held_accesses", 32'(log_q.size() - base_log), 32'd2);
    check("held_ready_after", 32'(ex_ready), 32'd1);

    // NOP and an undefined opcode are dropped
    base_log = log_q.size();
    p0 = pulses;
    issue(`OP_NOP, 32'h100, 32'h4, 32'h0, 5'd11, 5'd14, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    issue(4'hF, 32'h100, 32'h4, 32'h0, 5'd12, 5'd15, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    check("nop_accesses", 32'(log_q.size() - base_log), 32'd0);
    check("nop_pulses", 32'(pulses - p0), 32'd0);
    check("nop_ready", 32'(ex_ready), 32'd1);

    // Reset after the first SW byte: abandon, no CDB pulse
    base_log = log_q.size();
    p0 = pulses;
    issue(`OP_SW, 32'h400, 32'h0, 32'h11223344, 5'd13, 5'd16, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (log_q.size() > base_log) seen = 1'b1;
    end
    if (!seen) fail_now("sw_first_ack_timeout");
    @(posedge clk);
    #2;
    check("sw_second_byte_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_mem_we", 32'(mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ex_ready", 32'(ex_ready), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check("arst_pulses", 32'(pulses - p0), 32'd0);
    check("arst_idle_req", 32'(mem_req), 32'd0);
    check("arst_accesses", 32'(log_q.size() - base_log), 32'd1);

    // LW at 0x102: rejected with the check enabled, byte-serial otherwise
    base_log = log_q.size();
`ifdef LS_ALIGN_CHECK_EN
    issue(`OP_LW, 32'h100, 32'h2, 32'h0, 5'd14, 5'd17, 1'b1, `dataFree, 5'd17, 1'b1, 1'b0);
    wait_cdb("mis_timeout", lat);
    check("mis_latency", 32'(lat), 32'd1);
    check("mis_accesses", 32'(log_q.size() - base_log), 32'd0);
`else
    issue(`OP_LW, 32'h100, 32'h2, 32'h0, 5'd14, 5'd17, 1'b1, 32'h5678BBAA, 5'd17, 1'b0, 1'b0);
    wait_cdb("mis_timeout", lat);
    check("mis_latency", 32'(lat), 32'd5);
    check("mis_accesses", 32'(log_q.size() - base_log), 32'd4);
    if (log_q.size() > base_log) check("mis_first_addr", log_q[base_log].addr, 32'h102);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end
endmodule
